uart_alu_if: RTL

//  Consumes bytes from the UART receiver. Assembles 3-byte commands in order:

---
 rtl/uart_alu_if_pkg.sv | 39 +++
 rtl/uart_alu_if_timeout.sv | 34 +++
 rtl/uart_alu_if.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_alu_if_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_alu_if_pkg                                                  |
// | Brief   : Shared widths, one-hot FSM encoding and ALU opcodes.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package uart_alu_if_pkg;

   localparam int DEF_N_BITS_DATA = 8;
   localparam int DEF_N_BITS_OP   = 6;
   localparam int N_STATES        = 6;

   localparam logic [N_STATES-1:0] C_ST_WAIT_A  = 6'b000001;
   localparam logic [N_STATES-1:0] C_ST_WAIT_B  = 6'b000010;
   localparam logic [N_STATES-1:0] C_ST_WAIT_OP = 6'b000100;
   localparam logic [N_STATES-1:0] C_ST_EXEC    = 6'b001000;
   localparam logic [N_STATES-1:0] C_ST_SEND    = 6'b010000;
   localparam logic [N_STATES-1:0] C_ST_WAIT_TX = 6'b100000;

   typedef enum logic [N_STATES-1:0] {
      ST_WAIT_A  = C_ST_WAIT_A,
      ST_WAIT_B  = C_ST_WAIT_B,
      ST_WAIT_OP = C_ST_WAIT_OP,
      ST_EXEC    = C_ST_EXEC,
      ST_SEND    = C_ST_SEND,
      ST_WAIT_TX = C_ST_WAIT_TX
   } state_t;

   localparam logic [DEF_N_BITS_OP-1:0] C_OP_ADD = 6'h20;
   localparam logic [DEF_N_BITS_OP-1:0] C_OP_SUB = 6'h22;
   localparam logic [DEF_N_BITS_OP-1:0] C_OP_AND = 6'h24;
   localparam logic [DEF_N_BITS_OP-1:0] C_OP_OR  = 6'h25;
   localparam logic [DEF_N_BITS_OP-1:0] C_OP_XOR = 6'h26;
   localparam logic [DEF_N_BITS_OP-1:0] C_OP_NOR = 6'h27;
   localparam logic [DEF_N_BITS_OP-1:0] C_OP_SRA = 6'h03;
   localparam logic [DEF_N_BITS_OP-1:0] C_OP_SRL = 6'h02;

endpackage
`default_nettype wire

// File: rtl/uart_alu_if_timeout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cmd_timeout_counter                                              |
// | Brief   : Idle-cycle counter; pulses expired on its last count.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cmd_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 10_000_000,
   parameter int N_BITS_TIMEOUT = 24
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic expired
);

   localparam logic [N_BITS_TIMEOUT-1:0] C_LAST = N_BITS_TIMEOUT'(TIMEOUT_CYCLES - 1);

   logic [N_BITS_TIMEOUT-1:0] r_count;

   assign expired = enable && (r_count == C_LAST);

   // Clearing at expiry keeps the increment from ever wrapping.
   always_ff @(posedge clock) begin
      if (reset || clear || !enable || expired) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + N_BITS_TIMEOUT'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_alu_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_alu_if                                                      |
// | Brief   : Assembles A/B/opcode bytes from UART RX, drives the ALU, and     |
// |           hands the result to UART TX.                                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_alu_if
   import uart_alu_if_pkg::*;
#(
   parameter int N_BITS_DATA    = DEF_N_BITS_DATA,
   parameter int N_BITS_OP      = DEF_N_BITS_OP,
   parameter int TIMEOUT_CYCLES = 10_000_000,
   parameter int N_BITS_TIMEOUT = 24
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   rx_done_tick,
   input  logic [N_BITS_DATA-1:0] rx_data_i,
   input  logic [N_BITS_DATA-1:0] alu_result_i,
   input  logic                   tx_done_tick,
   output logic [N_BITS_DATA-1:0] alu_a_o,
   output logic [N_BITS_DATA-1:0] alu_b_o,
   output logic [N_BITS_OP-1:0]   alu_op_o,
   output logic                   tx_start_o,
   output logic [N_BITS_DATA-1:0] tx_data_o,
   output logic                   busy_o,
   output logic                   overrun_o,
   output logic                   timeout_o
);

   state_t r_state;
   state_t w_next_state;

   logic [N_BITS_DATA-1:0] r_alu_a;
   logic [N_BITS_DATA-1:0] r_alu_b;
   logic [N_BITS_OP-1:0]   r_alu_op;
   logic [N_BITS_DATA-1:0] r_tx_data;
   logic                   r_overrun;
   logic                   r_timeout;

   logic w_load_a;
   logic w_load_b;
   logic w_load_op;
   logic w_load_tx;
   logic w_cnt_en;
   logic w_expired;
   logic w_overrun;
   logic w_timeout;

   cmd_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .N_BITS_TIMEOUT (N_BITS_TIMEOUT)
   ) u_timeout (
      .clock   (clock),
      .reset   (reset),
      .enable  (w_cnt_en),
      .clear   (rx_done_tick),
      .expired (w_expired)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_WAIT_A;
      end else begin
         r_state <= w_next_state;
      end
   end

   // A received byte always takes priority over a same-cycle timeout expiry.
   always_comb begin
      w_next_state = r_state;
      w_load_a     = 1'b0;
      w_load_b     = 1'b0;
      w_load_op    = 1'b0;
      w_load_tx    = 1'b0;
      w_cnt_en     = 1'b0;
      w_overrun    = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         ST_WAIT_A: begin
            if (rx_done_tick) begin
               w_load_a     = 1'b1;
               w_next_state = ST_WAIT_B;
            end
         end
         ST_WAIT_B: begin
            w_cnt_en = 1'b1;
            if (rx_done_tick) begin
               w_load_b     = 1'b1;
               w_next_state = ST_WAIT_OP;
            end else if (w_expired) begin
               w_timeout    = 1'b1;
               w_next_state = ST_WAIT_A;
            end
         end
         ST_WAIT_OP: begin
            w_cnt_en = 1'b1;
            if (rx_done_tick) begin
               w_load_op    = 1'b1;
               w_next_state = ST_EXEC;
            end else if (w_expired) begin
               w_timeout    = 1'b1;
               w_next_state = ST_WAIT_A;
            end
         end
         ST_EXEC: begin
            w_overrun    = rx_done_tick;
            w_load_tx    = 1'b1;
            w_next_state = ST_SEND;
         end
         ST_SEND: begin
            w_overrun    = rx_done_tick;
            w_next_state = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            w_overrun = rx_done_tick;
            if (tx_done_tick) begin
               w_next_state = ST_WAIT_A;
            end
         end
         default: begin
            w_next_state = ST_WAIT_A;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_alu_a   <= '0;
         r_alu_b   <= '0;
         r_alu_op  <= '0;
         r_tx_data <= '0;
         r_overrun <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         if (w_load_a)  r_alu_a   <= rx_data_i;
         if (w_load_b)  r_alu_b   <= rx_data_i;
         if (w_load_op) r_alu_op  <= rx_data_i[N_BITS_OP-1:0];
         if (w_load_tx) r_tx_data <= alu_result_i;
         r_overrun <= w_overrun;
         r_timeout <= w_timeout;
      end
   end

   assign alu_a_o    = r_alu_a;
   assign alu_b_o    = r_alu_b;
   assign alu_op_o   = r_alu_op;
   assign tx_data_o  = r_tx_data;
   assign overrun_o  = r_overrun;
   assign timeout_o  = r_timeout;
   assign tx_start_o = (r_state == ST_SEND);
   assign busy_o     = (r_state == ST_EXEC) || (r_state == ST_SEND) || (r_state == ST_WAIT_TX);

endmodule
`default_nettype wire
